benes_subroute: RTL and testbench
=================================

# benes_subroute

Downstream of the first-level coloring stage in the 8x8 Benes router. When the coloring is valid, it builds the upper and lower 4x4 sub-permutations from `mp0..mp7`, `ci` and `co`. It then colors each 4x4 sub-network with a fixed two-step looping FSM and emits the complete 20-bit switch configuration for the 5-stage fabric. It also checks the first-level coloring and reports inconsistencies.

## Interface
No parameters; the network size is fixed at 8.

- `clk` in 1: single clock, rising edge.
- `areset` in 1: reset, asynchronous, active-high.
- `start` in 1: pulse; `ci`/`co`/`mp*` are valid and stable from this cycle until `valid`.
- `mp0..mp7` in 3 each: destination output of input i.
- `ci` in 8: `ci[i]` = sub-network carrying input i (0 upper, 1 lower).
- `co` in 8: `co[j]` = sub-network feeding output j.
- `sw` out 20: switch settings, 1 = cross, 0 = straight; held until next `valid`.
- `valid` out 1: one-cycle pulse, `sw`/`err` updated.
- `busy` out 1: high from start acceptance through the `valid` cycle.
- `err` out 1: coloring/permutation inconsistent; held with `sw`.

## Operation
- FSM states: IDLE → LOAD → STEP1 → STEP2 → DONE → IDLE.
- IDLE: `start`=1 is accepted. The inputs are registered, and the FSM moves to LOAD. `start` is ignored in every other state.
- LOAD builds the sub-permutations:
  - Upper: `up[i>>1] = mp_i>>1` for each i with `ci[i]=0`.
  - Lower: `lo[i>>1] = mp_i>>1` for each i with `ci[i]=1`.
- LOAD also evaluates the error condition. Error = any of:
  - `mp` is not a permutation;
  - `ci[2k]==ci[2k+1]` for some k;
  - `co[2k]==co[2k+1]` for some k;
  - `co[mp_i]!=ci[i]` for some i.
- On error, LOAD goes straight to DONE.
- STEP1 (both sub-networks in parallel, p = `up` or `lo`):
  - Set `c4[0]=0`, `c4[1]=1`.
  - Set `o4[p[0]]=0`, `o4[p[1]]=1`.
- STEP2:
  - If `p[0]>>1 == p[1]>>1`, then `c4[2]=0`.
  - Otherwise `c4[2] = ~o4[p[2]^1]`.
  - Then `c4[3]=~c4[2]`, `o4[p[2]]=c4[2]`, `o4[p[3]]=c4[3]`.
- Middle 2x2 switches, per sub-network:
  - `m0 = p[x]>>1` where x∈{0,1} has `c4[x]=0`.
  - `m1 = p[y]>>1` where y∈{0,1} has `c4[y]=1`.
- `sw` bit layout:
  - `sw[k] = ci[2k]`, k=0..3.
  - `sw[4+j]` = upper `c4[2j]`; `sw[6+j]` = lower `c4[2j]`.
  - `sw[8]`, `sw[9]` = upper `m0`, `m1`; `sw[10]`, `sw[11]` = lower `m0`, `m1`.
  - `sw[12+j]` = upper `o4[2j]`; `sw[14+j]` = lower `o4[2j]`.
  - `sw[16+k] = co[2k]`.
- DONE:
  - Register `sw`. On error, `sw` = 20'h0.
  - Assert `valid`; set `err` accordingly.
  - Return to IDLE.

## Timing
- Reset values: `sw`=0, `valid`=0, `busy`=0, `err`=0, FSM=IDLE, internal c4/o4/up/lo = 0.
- `start` sampled high at edge T:
  - `busy`=1 from T+1.
  - `valid`=1 during cycle T+4 (latency 4, fixed, including the error path).
  - `busy`=0 at T+5.
- Error path: LOAD→DONE skips the steps, but DONE is still held to cycle T+4. Achieve this by padding through STEP1/STEP2 with results discarded, so latency is constant.
- `start` high continuously: re-accepted at T+5 (the first IDLE cycle). Throughput is one job per 5 cycles.
- `areset` mid-job: immediate return to IDLE with all outputs at reset values. No `valid` is produced for the aborted job.
- `sw`/`err` change only on the `valid` cycle.

## Test plan
- Identity: `mp_i=i`, `ci`=8'hAA, `co`=8'hAA, start pulse → at start+4: `valid`=1, `sw`=20'h00000, `err`=0.
- Reversal: `mp_i=7-i`, `ci`=8'hAA, `co`=8'h55 → `sw`=20'hFFF00, `err`=0.
- Bad coloring: identity `mp`, `ci`=8'hFF → `valid` at start+4, `err`=1, `sw`=0. A following valid identity job clears `err` and gives `sw`=0.
- Randomized: 500 random permutations, with `ci`/`co` produced by a golden first-level looping model. Drive `sw` into a behavioral 8x8 Benes fabric; every input i must arrive at output `mp_i`, and `err`=0.
- Protocol: `start` pulsed again at start+2 → ignored, exactly one `valid`. `areset` pulsed at start+2 → no `valid`, all outputs 0. A new start afterwards completes normally at +4.

Source files
------------

// File: rtl/benes_subroute.sv
// benes_subroute: second-level router for the 8x8 Benes fabric.
// Takes the first-level coloring (ci/co) and the permutation, splits it
// into upper/lower 4x4 sub-permutations, colors both in parallel and
// emits the 20-bit switch configuration. Latency is a fixed 4 cycles.

// 4x4 sub-network looping colorer (one per half of the fabric)
module benes_sub4 (
   input  logic            clk,
   input  logic            rst,
   input  logic            step1,
   input  logic            step2,
   input  logic [3:0][1:0] p,
   output logic [3:0]      c4f,
   output logic [3:0]      o4f,
   output logic [1:0]      m
);
   logic [3:0] c4, o4;
   logic       c2;

   // finish the loop for inputs 2/3 and derive the middle 2x2 settings
   always_comb begin
      c2 = 1'b0;
      // if inputs 0/1 share an output switch, inputs 2/3 form a free loop
      if (p[0][1] != p[1][1])
         c2 = ~o4[p[2] ^ 2'd1];
      c4f       = {~c2, c2, c4[1:0]};
      o4f       = o4;
      o4f[p[2]] = c2;
      o4f[p[3]] = ~c2;
      m[0]      = c4[0] ? p[1][1] : p[0][1];
      m[1]      = c4[0] ? p[0][1] : p[1][1];
   end

   // coloring state: STEP1 seeds the loop, STEP2 closes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c4 <= '0;
         o4 <= '0;
      end else if (step1) begin
         c4[0]    <= 1'b0;
         c4[1]    <= 1'b1;
         o4[p[0]] <= 1'b0;
         o4[p[1]] <= 1'b1;
      end else if (step2) begin
         c4 <= c4f;
         o4 <= o4f;
      end
   end
endmodule

module benes_subroute (
   input  logic        clk,
   input  logic        areset,
   input  logic        start,
   input  logic [2:0]  mp0,
   input  logic [2:0]  mp1,
   input  logic [2:0]  mp2,
   input  logic [2:0]  mp3,
   input  logic [2:0]  mp4,
   input  logic [2:0]  mp5,
   input  logic [2:0]  mp6,
   input  logic [2:0]  mp7,
   input  logic [7:0]  ci,
   input  logic [7:0]  co,
   output logic [19:0] sw,
   output logic        valid,
   output logic        busy,
   output logic        err
);
   typedef enum logic [2:0] {IDLE, LOAD, STEP1, STEP2, DONE} state_t;

   typedef struct packed {
      logic [7:0][2:0] mp;
      logic [7:0]      ci;
      logic [7:0]      co;
   } job_t;

   state_t                state, state_nxt;
   job_t                  job;
   logic [1:0][3:0][1:0]  sub_p, p_nxt;   // [0] upper, [1] lower
   logic [7:0]            seen;
   logic                  err_nxt, err_r;
   logic [1:0][3:0]       c4f, o4f;
   logic [1:0][1:0]       m;
   logic [19:0]           sw_nxt;

   // sequence is fixed length so the error path keeps the same latency
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    state_nxt = STEP1;
         STEP1:   state_nxt = STEP2;
         STEP2:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // split into sub-permutations and validate the first-level coloring
   always_comb begin
      p_nxt   = '0;
      seen    = '0;
      err_nxt = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p_nxt[job.ci[i]][i/2] = job.mp[i][2:1];
         seen[job.mp[i]]       = 1'b1;
         if (job.co[job.mp[i]] != job.ci[i]) err_nxt = 1'b1;
      end
      for (int k = 0; k < 4; k++)
         if (job.ci[2*k] == job.ci[2*k+1] || job.co[2*k] == job.co[2*k+1])
            err_nxt = 1'b1;
      if (seen != 8'hFF) err_nxt = 1'b1;
   end

   for (genvar h = 0; h < 2; h++) begin : g_sub
      benes_sub4 u_sub (
         .clk   (clk),
         .rst   (areset),
         .step1 (state == STEP1),
         .step2 (state == STEP2),
         .p     (sub_p[h]),
         .c4f   (c4f[h]),
         .o4f   (o4f[h]),
         .m     (m[h])
      );
   end

   // assemble the 5-stage configuration from final sub-network colors
   always_comb begin
      sw_nxt = '0;
      for (int k = 0; k < 4; k++) begin
         sw_nxt[k]    = job.ci[2*k];
         sw_nxt[16+k] = job.co[2*k];
      end
      for (int h = 0; h < 2; h++) begin
         for (int j = 0; j < 2; j++) begin
            sw_nxt[4+2*h+j]  = c4f[h][2*j];
            sw_nxt[12+2*h+j] = o4f[h][2*j];
         end
         sw_nxt[8+2*h +: 2] = m[h];
      end
   end

   // job capture, sub-permutation load and result register
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
         job   <= '0;
         sub_p <= '0;
         err_r <= 1'b0;
         sw    <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start)
            job <= '{mp: {mp7, mp6, mp5, mp4, mp3, mp2, mp1, mp0}, ci: ci, co: co};
         if (state == LOAD) begin
            sub_p <= p_nxt;
            err_r <= err_nxt;
         end
         // results land on the edge into DONE so they are visible with valid
         if (state == STEP2) begin
            sw  <= err_r ? 20'h0 : sw_nxt;
            err <= err_r;
         end
      end
   end

   assign valid = (state == DONE);
   assign busy  = (state != IDLE);
endmodule

// File: tb/tb_benes_subroute.sv
// tb_benes_subroute: directed + randomized check of benes_subroute.
// Random jobs are colored by a first-level looping model and the returned
// configuration is pushed through a behavioural 8x8 Benes fabric.
module tb_benes_subroute;
   logic        clk = 1'b0;
   logic        areset;
   logic        start;
   logic [2:0]  mp [8];
   logic [7:0]  ci, co;
   logic [19:0] sw;
   logic        valid, busy, err;
   int          nchk = 0;
   int          nerr = 0;

   benes_subroute dut (
      .clk(clk), .areset(areset), .start(start),
      .mp0(mp[0]), .mp1(mp[1]), .mp2(mp[2]), .mp3(mp[3]),
      .mp4(mp[4]), .mp5(mp[5]), .mp6(mp[6]), .mp7(mp[7]),
      .ci(ci), .co(co), .sw(sw), .valid(valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // route input i through an 8x8 Benes fabric configured by s
   function automatic int route(input logic [19:0] s, input int i);
      int h, a, j, mm, q, b;
      h  = (i & 1) ^ int'(s[i/2]);
      a  = i / 2;
      j  = a / 2;
      mm = (a & 1) ^ int'(s[4+2*h+j]);
      q  = j ^ int'(s[8+2*h+mm]);
      b  = 2*q + (mm ^ int'(s[12+2*h+q]));
      return 2*b + (h ^ int'(s[16+b]));
   endfunction

   function automatic bit ref_err(input int m[8], input logic [7:0] a, input logic [7:0] b);
      int cnt[8];
      bit e;
      e = 0;
      for (int k = 0; k < 8; k++) cnt[k] = 0;
      for (int k = 0; k < 8; k++) cnt[m[k]]++;
      for (int k = 0; k < 8; k++) if (cnt[k] != 1) e = 1;
      for (int k = 0; k < 4; k++) if (a[2*k] == a[2*k+1] || b[2*k] == b[2*k+1]) e = 1;
      for (int k = 0; k < 8; k++) if (b[m[k]] != a[k]) e = 1;
      return e;
   endfunction

   task automatic rand_perm(output int m[8]);
      int t, r;
      for (int k = 0; k < 8; k++) m[k] = k;
      for (int k = 7; k > 0; k--) begin
         r = $urandom_range(0, k);
         t = m[k]; m[k] = m[r]; m[r] = t;
      end
   endtask

   // first-level looping: walk each input/output cycle alternating colors
   task automatic gold_color(input int m[8], output logic [7:0] gci, output logic [7:0] gco);
      int inv[8], cc[8];
      int i, jo, i2, c, guard;
      for (int k = 0; k < 8; k++) begin inv[m[k]] = k; cc[k] = -1; end
      gci = '0; gco = '0;
      for (int s = 0; s < 8; s++) begin
         if (cc[s] < 0) begin
            i = s; c = int'($urandom_range(0, 1)); guard = 0;
            while (cc[i] < 0 && guard < 16) begin
               cc[i] = c; gci[i] = c[0]; gco[m[i]] = c[0];
               jo = m[i] ^ 1; gco[jo] = ~c[0];
               i2 = inv[jo]; cc[i2] = 1 - c; gci[i2] = ~c[0];
               i = i2 ^ 1; guard++;
            end
         end
      end
   endtask

   task automatic drive(input int m[8], input logic [7:0] a, input logic [7:0] b);
      for (int k = 0; k < 8; k++) mp[k] = 3'(m[k]);
      ci = a; co = b;
   endtask

   // one job: start in cycle T, expect valid in cycle T+4, idle at T+5
   task automatic do_job(output logic [19:0] s, output logic e);
      int n;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("busy_on", busy, 1);
      n = 1;
      while (!valid && n < 10) begin @(negedge clk); n++; end
      chk("latency", n, 4);
      s = sw; e = err;
      @(negedge clk);
      chk("valid_pulse", valid, 0);
      chk("busy_off", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          m[8], idm[8], rvm[8];
      logic [19:0] s;
      logic        e, xe;
      logic [7:0]  gci, gco, okm;
      int          nv, first, sel;

      for (int k = 0; k < 8; k++) begin idm[k] = k; rvm[k] = 7 - k; end
      areset = 1'b1; start = 1'b0;
      drive(idm, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      areset = 1'b0;
      @(negedge clk);
      chk("rst_out", {sw, valid, busy, err}, 0);

      drive(idm, 8'hAA, 8'hAA);
      do_job(s, e);
      chk("id_sw", s, 20'h00000); chk("id_err", e, 0);

      drive(rvm, 8'hAA, 8'h55);
      do_job(s, e);
      chk("rev_sw", s, 20'hFFF00); chk("rev_err", e, 0);

      drive(idm, 8'hFF, 8'hAA);
      do_job(s, e);
      chk("bad_sw", s, 20'h0); chk("bad_err", e, 1);
      chk("bad_hold", sw, 20'h0);

      drive(idm, 8'hAA, 8'hAA);
      do_job(s, e);
      chk("clr_sw", s, 20'h0); chk("clr_err", e, 0);

      // second start while busy must be ignored
      drive(rvm, 8'hAA, 8'h55);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      nv = 0; first = -1;
      for (int c = 1; c <= 12; c++) begin
         start = (c == 2);
         if (valid) begin nv++; if (first < 0) first = c; end
         @(negedge clk);
      end
      start = 1'b0;
      chk("dbl_count", nv, 1); chk("dbl_at", first, 4);
      chk("dbl_sw", sw, 20'hFFF00);

      // reset mid-job: no valid, outputs cleared
      drive(idm, 8'hAA, 8'hAA);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); areset = 1'b1;
      #1;
      chk("arst_out", {sw, valid, busy, err}, 0);
      @(negedge clk); areset = 1'b0;
      nv = 0;
      for (int c = 0; c < 6; c++) begin if (valid) nv++; @(negedge clk); end
      chk("arst_novalid", nv, 0);
      chk("arst_sw", sw, 20'h0);
      drive(rvm, 8'hAA, 8'h55);
      do_job(s, e);
      chk("post_sw", s, 20'hFFF00); chk("post_err", e, 0);

      // randomized: 500 golden colorings, then corrupted ones
      for (int t = 0; t < 600; t++) begin
         rand_perm(m);
         gold_color(m, gci, gco);
         if (t >= 500) begin
            sel = $urandom_range(0, 7);
            case ($urandom_range(0, 2))
               0:       gci[sel] = ~gci[sel];
               1:       gco[sel] = ~gco[sel];
               default: m[sel] = $urandom_range(0, 7);
            endcase
         end
         xe = ref_err(m, gci, gco);
         drive(m, gci, gco);
         do_job(s, e);
         chk("rnd_err", e, xe);
         if (xe) chk("rnd_sw0", s, 0);
         else begin
            okm = '0;
            for (int i = 0; i < 8; i++) okm[i] = (route(s, i) == m[i]);
            chk("rnd_route", okm, 8'hFF);
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
